// File: rtl/cam_frame_ctrl.sv
// Capture sequencer: arms on command, aligns to a CAM_vsync rising edge, and gates the
// capture block's write strobe so that only whole frames reach the frame-buffer RAM.
module cam_frame_ctrl #(
    parameter int AW       = 15,
    parameter int DW       = 12,
    parameter int IMA_SIZE = 19200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CAM_vsync,
    input  logic          cap_regW,
    input  logic [AW-1:0] cap_addr,
    input  logic [DW-1:0] cap_data,
    input  logic          cmd_start,
    input  logic          cmd_mode,
    input  logic          cmd_stop,
    input  logic          cmd_abort,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          busy,
    output logic          frame_done,
    output logic [7:0]    frame_cnt,
    output logic [AW:0]   px_cnt,
    output logic          err_short,
    output logic          err_long
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

    localparam logic [AW:0] IMA_LIM = (AW+1)'(IMA_SIZE);

    state_t          state_q, state_d;
    logic            vs_q, vs_d;
    logic            mode_q, mode_d;
    logic            stop_q, stop_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_data_q, mem_data_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic [AW:0]     px_cnt_q, px_cnt_d;
    logic            err_short_q, err_short_d;
    logic            err_long_q, err_long_d;
    logic            vs_rise;

    assign vs_rise = CAM_vsync & ~vs_q;

    always_comb begin
        state_d      = state_q;
        vs_d         = CAM_vsync;
        mode_d       = mode_q;
        stop_d       = stop_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        px_cnt_d     = px_cnt_q;
        err_short_d  = err_short_q;
        err_long_d   = err_long_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    state_d = S_ARM;
                    mode_d  = cmd_mode;
                end
            end
            S_ARM: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (vs_rise) begin
                    state_d     = S_CAPTURE;
                    px_cnt_d    = '0;
                    err_short_d = 1'b0;
                    err_long_d  = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (cap_regW) begin
                    if (px_cnt_q < IMA_LIM) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = cap_addr;
                        mem_data_d = cap_data;
                        px_cnt_d   = px_cnt_q + 1'b1;
                    end else begin
                        err_long_d = 1'b1;
                    end
                end
                if (cmd_stop) begin
                    stop_d = 1'b1;
                end
                // A strobe coincident with the closing edge still counts toward this frame.
                if (vs_rise) begin
                    state_d      = S_DONE;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                    err_short_d  = (px_cnt_d < IMA_LIM);
                end
            end
            S_DONE: begin
                if (!mode_q || stop_q || cmd_stop) begin
                    state_d = S_IDLE;
                end else begin
                    // The edge that closed the last frame also opened this one.
                    state_d     = S_CAPTURE;
                    px_cnt_d    = '0;
                    err_short_d = 1'b0;
                    err_long_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cmd_abort) begin
            state_d      = S_IDLE;
            mode_d       = mode_q;
            mem_we_d     = 1'b0;
            mem_addr_d   = mem_addr_q;
            mem_data_d   = mem_data_q;
            frame_done_d = 1'b0;
            frame_cnt_d  = frame_cnt_q;
            px_cnt_d     = px_cnt_q;
            err_short_d  = err_short_q;
            err_long_d   = err_long_q;
        end

        if (state_d == S_IDLE) begin
            stop_d = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vs_q         <= 1'b0;
            mode_q       <= 1'b0;
            stop_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            px_cnt_q     <= '0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vs_d;
            mode_q       <= mode_d;
            stop_q       <= stop_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            px_cnt_q     <= px_cnt_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign px_cnt     = px_cnt_q;
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;

endmodule

// File: tb/tb_cam_frame_ctrl.sv
// Directed testbench for cam_frame_ctrl: whole-frame gating, continuous mode, size errors,
// abort, simultaneous events, reset mid-frame and frame counter wrap.
module tb_cam_frame_ctrl;

    localparam int AW = 15;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          CAM_vsync;
    logic          cap_regW;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_data;
    logic          cmd_start;
    logic          cmd_mode;
    logic          cmd_stop;
    logic          cmd_abort;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frame_cnt;
    logic [AW:0]   px_cnt;
    logic          err_short;
    logic          err_long;

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;
    int fd_cnt = 0;
    int addr_bad = 0;
    int idx = 0;

    always #5 clk = ~clk;

    cam_frame_ctrl #(.AW(AW), .DW(DW), .IMA_SIZE(19200)) dut (
        .clk(clk), .rst(rst), .CAM_vsync(CAM_vsync), .cap_regW(cap_regW),
        .cap_addr(cap_addr), .cap_data(cap_data), .cmd_start(cmd_start),
        .cmd_mode(cmd_mode), .cmd_stop(cmd_stop), .cmd_abort(cmd_abort),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .px_cnt(px_cnt),
        .err_short(err_short), .err_long(err_long)
    );

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] v;
        v = i;
        return v[DW-1:0] ^ 12'h5A3;
    endfunction

    // Every stored write must carry the next in-frame address and its matching pixel.
    always @(negedge clk) begin
        int nidx;
        nidx = idx;
        if (mem_we) begin
            if (mem_addr !== AW'(idx) || mem_data !== pat(idx)) addr_bad <= addr_bad + 1;
            nidx = idx + 1;
            we_cnt <= we_cnt + 1;
        end
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (frame_done || !busy) nidx = 0;
        idx <= nidx;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            cap_regW = 1'b1;
            cap_addr = AW'(first + i);
            cap_data = pat(first + i);
            cyc();
        end
        cap_regW = 1'b0;
    endtask

    task automatic pulse_start(input logic mode);
        cmd_start = 1'b1;
        cmd_mode  = mode;
        cyc();
        cmd_start = 1'b0;
        cmd_mode  = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
    endtask

    task automatic vs_rise_step();
        CAM_vsync = 1'b1;
        cyc();
    endtask

    task automatic vs_tail();
        cyc();
        cyc();
        CAM_vsync = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        tests++;
        if ({mem_we, busy, frame_done, err_short, err_long} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got we=%b busy=%b fd=%b es=%b el=%b want all 0",
                     mem_we, busy, frame_done, err_short, err_long);
        end
        tests++;
        if (frame_cnt !== 8'd0 || px_cnt !== '0 || mem_addr !== '0 || mem_data !== '0) begin
            fails++;
            $display("FAIL reset_values: got fc=%0d px=%0d addr=%0d data=%h want 0",
                     frame_cnt, px_cnt, mem_addr, mem_data);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_single();
        int we0, fd0, bad0;
        we0 = we_cnt; fd0 = fd_cnt; bad0 = addr_bad;
        pulse_start(1'b0);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL single_arm_busy: got %b want 1", busy); end
        burst(0, 500);
        tests++;
        if (we_cnt - we0 !== 0) begin fails++; $display("FAIL single_arm_drop: got %0d writes want 0", we_cnt - we0); end
        vs_rise_step();
        vs_tail();
        cap_regW = 1'b1; cap_addr = '0; cap_data = pat(0);
        cyc();
        tests++;
        if (mem_we !== 1'b1 || mem_addr !== '0 || mem_data !== pat(0)) begin
            fails++;
            $display("FAIL single_latency: got we=%b addr=%0d want we=1 addr=0", mem_we, mem_addr);
        end
        burst(1, 19199);
        cyc();
        vs_rise_step();
        tests++;
        if (frame_done !== 1'b1 || frame_cnt !== 8'd1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_done: got fd=%b fc=%0d busy=%b want 1 1 1", frame_done, frame_cnt, busy);
        end
        cyc();
        tests++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL single_idle: got busy=%b fd=%b want 0 0", busy, frame_done);
        end
        CAM_vsync = 1'b0;
        cyc();
        tests++;
        if (we_cnt - we0 !== 19200 || fd_cnt - fd0 !== 1 || addr_bad !== bad0) begin
            fails++;
            $display("FAIL single_counts: got we=%0d fd=%0d bad=%0d want 19200 1 0",
                     we_cnt - we0, fd_cnt - fd0, addr_bad - bad0);
        end
        tests++;
        if (px_cnt !== 16'd19200 || err_short !== 1'b0 || err_long !== 1'b0) begin
            fails++;
            $display("FAIL single_stats: got px=%0d es=%b el=%b want 19200 0 0", px_cnt, err_short, err_long);
        end
        $display("[TB] single frame: writes=%0d frame_cnt=%0d", we_cnt - we0, frame_cnt);
    endtask

    task automatic test_continuous_stop();
        int we0, fd0;
        we0 = we_cnt; fd0 = fd_cnt;
        pulse_start(1'b1);
        vs_rise_step();
        vs_tail();
        for (int k = 0; k < 3; k++) begin
            burst(0, 100);
            if (k == 2) pulse_stop();
            vs_rise_step();
            tests++;
            if (frame_done !== 1'b1 || px_cnt !== 16'd100) begin
                fails++;
                $display("FAIL cont_done_%0d: got fd=%b px=%0d want 1 100", k, frame_done, px_cnt);
            end
            vs_tail();
        end
        tests++;
        if (busy !== 1'b0 || frame_cnt !== 8'd4) begin
            fails++;
            $display("FAIL cont_end: got busy=%b fc=%0d want 0 4", busy, frame_cnt);
        end
        tests++;
        if (fd_cnt - fd0 !== 3 || we_cnt - we0 !== 300) begin
            fails++;
            $display("FAIL cont_counts: got fd=%0d we=%0d want 3 300", fd_cnt - fd0, we_cnt - we0);
        end
        $display("[TB] continuous+stop: frames=%0d writes=%0d", fd_cnt - fd0, we_cnt - we0);
    endtask

    task automatic test_short_long();
        int we0, bad0;
        bad0 = addr_bad;
        pulse_start(1'b1);
        vs_rise_step();
        vs_tail();
        burst(0, 19000);
        vs_rise_step();
        tests++;
        if (err_short !== 1'b1 || err_long !== 1'b0 || px_cnt !== 16'd19000) begin
            fails++;
            $display("FAIL short_frame: got es=%b el=%b px=%0d want 1 0 19000", err_short, err_long, px_cnt);
        end
        vs_tail();
        tests++;
        if (px_cnt !== '0 || err_short !== 1'b0) begin
            fails++;
            $display("FAIL cont_clear: got px=%0d es=%b want 0 0", px_cnt, err_short);
        end
        we0 = we_cnt;
        burst(0, 19300);
        tests++;
        if (err_long !== 1'b1) begin fails++; $display("FAIL long_flag_early: got %b want 1", err_long); end
        pulse_stop();
        vs_rise_step();
        tests++;
        if (err_long !== 1'b1 || err_short !== 1'b0 || px_cnt !== 16'd19200) begin
            fails++;
            $display("FAIL long_frame: got el=%b es=%b px=%0d want 1 0 19200", err_long, err_short, px_cnt);
        end
        vs_tail();
        tests++;
        if (we_cnt - we0 !== 19200 || addr_bad !== bad0) begin
            fails++;
            $display("FAIL long_writes: got we=%0d bad=%0d want 19200 0", we_cnt - we0, addr_bad - bad0);
        end
        tests++;
        if (busy !== 1'b0 || err_long !== 1'b1 || frame_cnt !== 8'd6) begin
            fails++;
            $display("FAIL long_hold: got busy=%b el=%b fc=%0d want 0 1 6", busy, err_long, frame_cnt);
        end
        $display("[TB] short/long: frame_cnt=%0d px=%0d", frame_cnt, px_cnt);
    endtask

    task automatic test_abort();
        int we0, fd0;
        pulse_start(1'b0);
        vs_rise_step();
        vs_tail();
        we0 = we_cnt; fd0 = fd_cnt;
        burst(0, 9999);
        cap_regW = 1'b1; cap_addr = AW'(9999); cap_data = pat(9999); cmd_abort = 1'b1;
        cyc();
        cap_regW = 1'b0; cmd_abort = 1'b0;
        tests++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL abort_now: got we=%b busy=%b fd=%b want 0 0 0", mem_we, busy, frame_done);
        end
        tests++;
        if (px_cnt !== 16'd9999 || we_cnt - we0 !== 9999) begin
            fails++;
            $display("FAIL abort_count: got px=%0d we=%0d want 9999 9999", px_cnt, we_cnt - we0);
        end
        vs_rise_step();
        vs_tail();
        tests++;
        if (fd_cnt !== fd0 || frame_cnt !== 8'd6) begin
            fails++;
            $display("FAIL abort_noframe: got fd=%0d fc=%0d want %0d 6", fd_cnt, frame_cnt, fd0);
        end
        pulse_start(1'b0);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL rearm_busy: got %b want 1", busy); end
        vs_rise_step();
        vs_tail();
        burst(0, 10);
        vs_rise_step();
        tests++;
        if (frame_done !== 1'b1 || frame_cnt !== 8'd7 || px_cnt !== 16'd10) begin
            fails++;
            $display("FAIL rearm_done: got fd=%b fc=%0d px=%0d want 1 7 10", frame_done, frame_cnt, px_cnt);
        end
        vs_tail();
        $display("[TB] abort: frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_simultaneous();
        cmd_start = 1'b1; cmd_abort = 1'b1; cmd_mode = 1'b1;
        cyc();
        cmd_start = 1'b0; cmd_abort = 1'b0; cmd_mode = 1'b0;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL start_abort: got busy=%b want 0", busy); end
        pulse_start(1'b0);
        pulse_stop();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL arm_stop: got busy=%b want 0", busy); end
        pulse_start(1'b0);
        pulse_start(1'b1);
        vs_rise_step();
        vs_tail();
        burst(0, 5);
        cap_regW = 1'b1; cap_addr = AW'(5); cap_data = pat(5); CAM_vsync = 1'b1;
        cyc();
        cap_regW = 1'b0;
        tests++;
        if (frame_done !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(5) || px_cnt !== 16'd6) begin
            fails++;
            $display("FAIL coincident: got fd=%b we=%b addr=%0d px=%0d want 1 1 5 6",
                     frame_done, mem_we, mem_addr, px_cnt);
        end
        cyc();
        tests++;
        if (busy !== 1'b0 || frame_cnt !== 8'd8) begin
            fails++;
            $display("FAIL mode_kept: got busy=%b fc=%0d want 0 8", busy, frame_cnt);
        end
        CAM_vsync = 1'b0;
        cyc();
        $display("[TB] simultaneous events: frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_reset_wrap();
        int fd0;
        pulse_start(1'b1);
        vs_rise_step();
        vs_tail();
        burst(0, 4999);
        cap_regW = 1'b1; cap_addr = AW'(4999); cap_data = pat(4999); rst = 1'b1;
        cyc();
        cap_regW = 1'b0; rst = 1'b0;
        tests++;
        if ({mem_we, busy, frame_done, err_short, err_long} !== 5'b0 || frame_cnt !== 8'd0) begin
            fails++;
            $display("FAIL midreset_flags: got we=%b busy=%b fd=%b es=%b el=%b fc=%0d want 0",
                     mem_we, busy, frame_done, err_short, err_long, frame_cnt);
        end
        tests++;
        if (px_cnt !== '0 || mem_addr !== '0 || mem_data !== '0) begin
            fails++;
            $display("FAIL midreset_values: got px=%0d addr=%0d data=%h want 0", px_cnt, mem_addr, mem_data);
        end
        pulse_start(1'b1);
        vs_rise_step();
        vs_tail();
        fd0 = fd_cnt;
        for (int k = 0; k < 256; k++) begin
            burst(0, 1);
            if (k == 255) pulse_stop();
            vs_rise_step();
            if (k == 254) begin
                tests++;
                if (frame_cnt !== 8'd255) begin fails++; $display("FAIL wrap_255: got %0d want 255", frame_cnt); end
            end
            if (k == 255) begin
                tests++;
                if (frame_cnt !== 8'd0) begin fails++; $display("FAIL wrap_0: got %0d want 0", frame_cnt); end
            end
            vs_tail();
        end
        tests++;
        if (busy !== 1'b0 || fd_cnt - fd0 !== 256) begin
            fails++;
            $display("FAIL wrap_end: got busy=%b fd=%0d want 0 256", busy, fd_cnt - fd0);
        end
        $display("[TB] reset mid-frame + wrap: frames=%0d frame_cnt=%0d", fd_cnt - fd0, frame_cnt);
    endtask

    initial begin
        rst = 1'b1; CAM_vsync = 1'b0; cap_regW = 1'b0; cap_addr = '0; cap_data = '0;
        cmd_start = 1'b0; cmd_mode = 1'b0; cmd_stop = 1'b0; cmd_abort = 1'b0;
        test_reset();
        test_single();
        test_continuous_stop();
        test_short_long();
        test_abort();
        test_simultaneous();
        test_reset_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
